// File: rtl/instr_loader_pkg.sv
// Shared state encoding, framing constants and address helper for the boot-time instruction loader.
// No logic; no latency or backpressure of its own.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] word_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Packs MSB-first stream bytes into 32-bit words; word_vld is combinational with the last byte's handshake.
// Latency: 0 cycles from 4th byte to word_vld; no backpressure (accepts whenever byte_vld is high).
module instr_loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam logic [1:0] LANE_LAST = 2'(WORD_BYTES - 1);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clr) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (byte_vld) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_dat};
    end
  end

  // The first three bytes already sit in the shift register when the fourth arrives.
  assign word_vld = byte_vld && (lane_q == LANE_LAST);
  assign word_dat = {shift_q, byte_dat};

endmodule

// File: rtl/instr_loader.sv
// Loads a framed byte image (count header, BE words, XOR checksum) into instruction memory, holding the core until verified.
// Latency: IMWrite one cycle after a word's 4th byte, Done/Error one cycle after the checksum byte; ByteReady is never dropped mid-load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int CNT_W       = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  input  logic        Reload,
  output logic        IMWrite,
  output logic [31:0] IMAddr,
  output logic [31:0] IMData,
  output logic        CoreHold,
  output logic        Done,
  output logic        Error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

  state_t state_q, state_d;

  logic [7:0]       hdr_hi_q;
  logic [7:0]       csum_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_inc;
  logic [CNT_W-1:0] hdr_cnt;
  logic             rdy_q, wr_q, hold_q, done_q, err_q;
  logic [31:0]      addr_q, data_q;
  logic             xfer, reload_go, pk_vld, word_vld;
  logic [31:0]      word_dat;

  assign xfer      = ByteValid & rdy_q;
  assign reload_go = Reload & ((state_q == ST_DONE) || (state_q == ST_ERR));
  assign pk_vld    = xfer & (state_q == ST_DATA);
  assign idx_inc   = idx_q + CNT_W'(1);
  assign hdr_cnt   = CNT_W'({hdr_hi_q, ByteIn});

  instr_loader_word_packer u_packer (
    .clk      (Clock),
    .rst_n    (Reset),
    .clr      (reload_go),
    .byte_vld (pk_vld),
    .byte_dat (ByteIn),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (hdr_cnt > DEPTH_C)       state_d = ST_ERR;
          else if (hdr_cnt == '0)      state_d = ST_CSUM;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA:   if (word_vld && (idx_inc == n_q)) state_d = ST_CSUM;
      ST_CSUM:   if (xfer) state_d = (ByteIn == csum_q) ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:    if (Reload) state_d = ST_LEN_HI;
      default:   state_d = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_LEN_HI;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdy_q    <= 1'b0;
      wr_q     <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hdr_hi_q <= '0;
      csum_q   <= '0;
      n_q      <= '0;
      idx_q    <= '0;
    end else begin
      // Status flags track the upcoming state so they change with the transition edge.
      rdy_q  <= (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                (state_d == ST_DATA)   || (state_d == ST_CSUM);
      hold_q <= (state_d != ST_DONE);
      done_q <= (state_d == ST_DONE);
      err_q  <= (state_d == ST_ERR);
      wr_q   <= word_vld;
      if (word_vld) begin
        addr_q <= word_addr(30'(idx_q));
        data_q <= word_dat;
      end
      if (reload_go) begin
        hdr_hi_q <= '0;
        csum_q   <= '0;
        n_q      <= '0;
        idx_q    <= '0;
      end else begin
        if (xfer && (state_q == ST_LEN_HI)) hdr_hi_q <= ByteIn;
        if (xfer && (state_q == ST_LEN_LO)) n_q <= hdr_cnt;
        if (pk_vld)   csum_q <= csum_q ^ ByteIn;
        if (word_vld) idx_q  <= idx_inc;
      end
    end
  end

  assign ByteReady = rdy_q;
  assign IMWrite   = wr_q;
  assign IMAddr    = addr_q;
  assign IMData    = data_q;
  assign CoreHold  = hold_q;
  assign Done      = done_q;
  assign Error     = err_q;

endmodule
